regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side front end for the core's 32×32 register file. It accepts results from two producers, the ALU and the load/store unit, over valid/ready handshakes and arbitrates between them. The winning result drives the register file's single write port (`wr_en`/`wr_index`/`wr_data`) through one register stage. It also keeps a pending-write scoreboard that the issue stage uses to stall reads of registers whose results are still in flight.

## Interface
Parameters:
- `XLEN`, 32, data width
- `IDX_W`, 5, register index width (2^IDX_W registers)
- `STARVE_MAX`, 3, consecutive LSU wins allowed while ALU waits

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result valid
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  IDX_W  ALU destination index
- `alu_data`  in  XLEN  ALU result
- `lsu_valid`  in  1  load result valid
- `lsu_ready`  out  1  load result accepted this cycle
- `lsu_rd`  in  IDX_W  load destination index
- `lsu_data`  in  XLEN  load data
- `issue_en`  in  1  issue stage dispatches an instruction that writes `issue_rd`
- `issue_rd`  in  IDX_W  destination being reserved
- `wr_en`  out  1  register file write enable
- `wr_index`  out  IDX_W  register file write index
- `wr_data`  out  XLEN  register file write data
- `busy`  out  2^IDX_W  scoreboard; bit i set means a write to xi is pending
- `err_waw`  out  1  sticky; set when an issue targets a register already busy

## Operation
- Handshake: a transfer occurs when `valid && ready` are both high at the rising edge of `clk`. `ready` is combinational from the valid inputs and arbiter state. At most one source is accepted per cycle.
- Arbitration:
  - LSU has fixed priority.
  - A starvation counter `starve` counts consecutive cycles in which the LSU won while `alu_valid` was high.
  - When `starve == STARVE_MAX`, the ALU wins the next contended cycle and `starve` clears.
  - `starve` also clears on any ALU acceptance and on any cycle in which `alu_valid` is low.
- Write stage:
  - On acceptance, `wr_index`/`wr_data` load the winner's rd and data.
  - `wr_en` loads 1 if rd != 0, else 0. Results destined for x0 are consumed silently.
  - `wr_en` loads 0 in any cycle with no acceptance. `wr_index`/`wr_data` then hold their previous values.
- Scoreboard:
  - `issue_en` with `issue_rd` != 0 sets `busy[issue_rd]` at the next edge.
  - An acceptance with rd != 0 clears `busy[rd]` at the next edge.
  - If the set and clear target the same index in the same cycle, the set wins, because the new producer owns the register.
  - `busy[0]` is constant 0.
- WAW: `issue_en` to an index whose `busy` bit is already 1 sets `err_waw`, which holds until reset. The `busy` bit stays 1.
- A producer writing an rd that is not busy is legal: the write proceeds and no error is raised.

## Timing
- Reset values: `wr_en` 0, `wr_index` 0, `wr_data` 0, `busy` all 0, `err_waw` 0, `starve` 0. `alu_ready`/`lsu_ready` are 0 while `reset_n` is low.
- Latency: a result accepted at edge N appears at the register file with `wr_en` high during cycle N+1 and is written at edge N+1.
- The `busy` clear becomes visible in the same cycle N+1 that `wr_en` is high. A read issued in that cycle relies on the register file's write-to-read bypass.
- Throughput: one writeback per cycle.
- When both sources are valid, the losing source's `ready` is 0 and it must hold `valid`, rd and data stable until accepted.
- When only one source is valid, it is accepted in that cycle regardless of `starve`.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight results are lost and the scoreboard clears.

## Structure
- The shared core package holds `XLEN`, `IDX_W`, the constant `REG_ZERO = 0`, and an enum `wb_src_e {WB_NONE, WB_ALU, WB_LSU}`.
- One sub-module, `wb_arbiter`. It contains the two-source priority arbiter with the starvation counter and outputs both readies plus the selected `wb_src_e`.
- The write-stage register, scoreboard and `err_waw` logic live in the top module.

## Test plan
- ALU only: `alu_valid`=1, rd=5, data=0xDEADBEEF -> `alu_ready`=1 in the same cycle. Next cycle `wr_en`=1, `wr_index`=5, `wr_data`=0xDEADBEEF.
- Contention: both valid continuously, ALU rd=1, LSU rd=2, STARVE_MAX=3 -> winners are LSU, LSU, LSU, ALU, LSU…; the ALU is never blocked for more than 3 cycles.
- x0 drop: LSU rd=0, data=0x1234 -> `lsu_ready`=1; next cycle `wr_en`=0 and `busy` is unchanged.
- Scoreboard: `issue_en` rd=7 -> `busy[7]`=1 next cycle. Later an ALU write to rd=7 is accepted at edge N -> `busy[7]`=0 and `wr_en`=1 both in cycle N+1.
- Simultaneous set and clear on rd=9, then a second issue to rd=9 while it is busy -> `busy[9]` stays 1 and `err_waw`=1 until reset.
- Assert `reset_n` low while `busy`=0x0000_0F00 and `wr_en`=1 -> `busy`=0, `wr_en`=0 and `err_waw`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared core definitions for the register-file writeback front end.
//   XLEN      : default data width
//   IDX_W     : default register index width
//   REG_ZERO  : index of the hard-wired zero register
//   wb_src_e  : which producer (if any) won writeback arbitration this cycle
package regfile_writeback_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: the LSU has fixed priority, and a starvation
// counter lets a waiting ALU win after STARVE_MAX consecutive LSU wins.
//   clk, reset_n         : clock, asynchronous active-low reset
//   alu_valid, lsu_valid : producer requests
//   alu_ready, lsu_ready : combinational grants (0 while in reset)
//   sel_c                : combinational winner for this cycle
module wb_arbiter
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    alu_valid,
    input  logic    lsu_valid,
    output logic    alu_ready,
    output logic    lsu_ready,
    output wb_src_e sel_c
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve;
    logic [CNT_W-1:0] starve_next;
    logic             starved;

    // Grant selection and starvation counter update.
    always_comb begin
        alu_ready   = 1'b0;
        lsu_ready   = 1'b0;
        sel_c       = WB_NONE;
        starve_next = starve;
        starved     = (starve == CNT_W'(STARVE_MAX));

        if (reset_n) begin
            alu_ready = alu_valid && (!lsu_valid || starved);
            lsu_ready = lsu_valid && !alu_ready;
        end

        if (alu_ready) begin
            sel_c = WB_ALU;
        end else if (lsu_ready) begin
            sel_c = WB_LSU;
        end

        // Only LSU wins while the ALU is waiting extend the streak.
        if (!alu_valid || alu_ready) begin
            starve_next = '0;
        end else if (lsu_ready && !starved) begin
            starve_next = starve + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve <= '0;
        end else begin
            starve <= starve_next;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the register file: arbitrates ALU/LSU results onto
// the single write port through one register stage, and tracks in-flight
// destinations in a pending-write scoreboard.
//   clk, reset_n                          : clock, asynchronous active-low reset
//   alu_valid/ready/rd/data               : ALU result handshake
//   lsu_valid/ready/rd/data               : load result handshake
//   issue_en, issue_rd                    : destination reservation from issue
//   wr_en, wr_index, wr_data              : registered register-file write port
//   busy                                  : pending-write scoreboard, bit 0 always 0
//   err_waw                               : sticky issue-to-busy-register flag
module regfile_writeback #(
    parameter int unsigned XLEN       = regfile_writeback_pkg::XLEN,
    parameter int unsigned IDX_W      = regfile_writeback_pkg::IDX_W,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [IDX_W-1:0]      alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [IDX_W-1:0]      lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_en,
    input  logic [IDX_W-1:0]      issue_rd,
    output logic                  wr_en,
    output logic [IDX_W-1:0]      wr_index,
    output logic [XLEN-1:0]       wr_data,
    output logic [(2**IDX_W)-1:0] busy,
    output logic                  err_waw
);

    import regfile_writeback_pkg::*;

    localparam int unsigned NREGS = 2 ** IDX_W;

    wb_src_e          sel;
    logic             accepted;
    logic             acc_nz;
    logic [IDX_W-1:0] acc_rd;
    logic [XLEN-1:0]  acc_data;
    logic [NREGS-1:0] busy_next;
    logic             err_next;

    wb_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .lsu_valid (lsu_valid),
        .alu_ready (alu_ready),
        .lsu_ready (lsu_ready),
        .sel_c     (sel)
    );

    // Winner mux, scoreboard next state and WAW detection.
    always_comb begin
        accepted  = (sel != WB_NONE);
        acc_rd    = alu_rd;
        acc_data  = alu_data;
        busy_next = busy;
        err_next  = err_waw;

        if (sel == WB_LSU) begin
            acc_rd   = lsu_rd;
            acc_data = lsu_data;
        end
        acc_nz = accepted && (acc_rd != IDX_W'(REG_ZERO));

        if (acc_nz) begin
            busy_next[acc_rd] = 1'b0;
        end
        // Set after clear: a new reservation owns the register.
        if (issue_en && (issue_rd != IDX_W'(REG_ZERO))) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;

        if (issue_en && busy[issue_rd]) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en    <= 1'b0;
            wr_index <= '0;
            wr_data  <= '0;
            busy     <= '0;
            err_waw  <= 1'b0;
        end else begin
            wr_en <= acc_nz;
            if (accepted) begin
                wr_index <= acc_rd;
                wr_data  <= acc_data;
            end
            busy    <= busy_next;
            err_waw <= err_next;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by a
// randomized run against a behavioural reference model.
module tb_regfile_writeback;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned STARVE_MAX = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             alu_valid, alu_ready;
    logic [IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             lsu_valid, lsu_ready;
    logic [IDX_W-1:0] lsu_rd;
    logic [XLEN-1:0]  lsu_data;
    logic             issue_en;
    logic [IDX_W-1:0] issue_rd;
    logic             wr_en;
    logic [IDX_W-1:0] wr_index;
    logic [XLEN-1:0]  wr_data;
    logic [31:0]      busy;
    logic             err_waw;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_writeback #(
        .XLEN       (XLEN),
        .IDX_W      (IDX_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .busy      (busy),
        .err_waw   (err_waw)
    );

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_en  = 1'b0; issue_rd = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        #2;
        vectors++;
        if (wr_en !== 1'b0 || wr_index !== 5'd0 || wr_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_wr_port: got en=%b idx=%0d data=%h expected 0/0/0", wr_en, wr_index, wr_data);
        end
        vectors++;
        if (busy !== 32'd0 || err_waw !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_scoreboard: got busy=%h err=%b expected 0/0", busy, err_waw);
        end
        vectors++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got alu=%b lsu=%b expected 0/0", alu_ready, lsu_ready);
        end
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
    endtask

    task automatic test_alu_only();
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        vectors++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_only_ready: got alu=%b lsu=%b expected 1/0", alu_ready, lsu_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (wr_en !== 1'b1 || wr_index !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL alu_only_write: got en=%b idx=%0d data=%h expected 1/5/deadbeef", wr_en, wr_index, wr_data);
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        vectors++;
        if (wr_en !== 1'b0 || wr_index !== 5'd5 || wr_data !== 32'hDEADBEEF || err_waw !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_only_hold: got en=%b idx=%0d data=%h err=%b expected 0/5/deadbeef/0",
                     wr_en, wr_index, wr_data, err_waw);
        end
    endtask

    task automatic test_contention();
        bit exp_alu;
        int blocked;
        int max_blocked;
        blocked = 0;
        max_blocked = 0;
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAAAA_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hBBBB_0002;
        for (int i = 0; i < 8; i++) begin
            exp_alu = ((i % 4) == 3);
            #1;
            vectors++;
            if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
                miscompares++;
                $display("FAIL contention_ready[%0d]: got alu=%b lsu=%b expected alu=%b", i, alu_ready, lsu_ready, exp_alu);
            end
            blocked = alu_ready ? 0 : blocked + 1;
            if (blocked > max_blocked) max_blocked = blocked;
            @(posedge clk); #1;
            vectors++;
            if (wr_en !== 1'b1 || wr_index !== (exp_alu ? 5'd1 : 5'd2)) begin
                miscompares++;
                $display("FAIL contention_write[%0d]: got en=%b idx=%0d expected 1/%0d", i, wr_en, wr_index, exp_alu ? 1 : 2);
            end
            @(negedge clk);
        end
        vectors++;
        if (max_blocked > 3) begin
            miscompares++;
            $display("FAIL contention_starve_bound: got %0d blocked cycles expected at most 3", max_blocked);
        end
        drive_idle();
    endtask

    task automatic test_x0_drop();
        @(negedge clk);
        issue_en = 1'b1; issue_rd = 5'd3;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 32'h0000_0008) begin
            miscompares++;
            $display("FAIL x0_setup_busy: got %h expected 00000008", busy);
        end
        @(negedge clk);
        issue_en = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
        #1;
        vectors++;
        if (lsu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_ready: got %b expected 1", lsu_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (wr_en !== 1'b0 || busy !== 32'h0000_0008) begin
            miscompares++;
            $display("FAIL x0_drop: got en=%b busy=%h expected 0/00000008", wr_en, busy);
        end
        @(negedge clk);
        lsu_rd = 5'd3; lsu_data = 32'h55;
        @(posedge clk); #1;
        vectors++;
        if (wr_en !== 1'b1 || wr_index !== 5'd3 || busy !== 32'd0) begin
            miscompares++;
            $display("FAIL x0_cleanup: got en=%b idx=%0d busy=%h expected 1/3/0", wr_en, wr_index, busy);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue_en = 1'b1; issue_rd = 5'd7;
        @(posedge clk); #1;
        vectors++;
        if (busy[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_set: got busy[7]=%b expected 1", busy[7]);
        end
        @(negedge clk);
        issue_en = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 32'h0000_0080) begin
            miscompares++;
            $display("FAIL sb_hold: got %h expected 00000080", busy);
        end
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0707_0707;
        @(posedge clk); #1;
        vectors++;
        if (wr_en !== 1'b1 || wr_index !== 5'd7 || busy[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_clear: got en=%b idx=%0d busy[7]=%b expected 1/7/0", wr_en, wr_index, busy[7]);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_set_clear_waw();
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0909_0909;
        issue_en  = 1'b1; issue_rd = 5'd9;
        @(posedge clk); #1;
        vectors++;
        if (busy[9] !== 1'b1 || wr_en !== 1'b1 || err_waw !== 1'b0) begin
            miscompares++;
            $display("FAIL set_clear_same: got busy[9]=%b en=%b err=%b expected 1/1/0", busy[9], wr_en, err_waw);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (err_waw !== 1'b1 || busy[9] !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_detect: got err=%b busy[9]=%b expected 1/1", err_waw, busy[9]);
        end
        @(negedge clk);
        issue_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (err_waw !== 1'b1 || busy !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL waw_sticky: got err=%b busy=%h expected 1/00000200", err_waw, busy);
        end
    endtask

    task automatic test_async_reset();
        for (int r = 8; r <= 11; r++) begin
            if (r != 9) begin
                @(negedge clk);
                issue_en = 1'b1; issue_rd = 5'(r);
            end
        end
        @(negedge clk);
        issue_en = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_1111;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 32'h0000_0F00 || wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL async_setup: got busy=%h en=%b expected 00000f00/1", busy, wr_en);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 32'd0 || wr_en !== 1'b0 || err_waw !== 1'b0 || wr_index !== 5'd0 || wr_data !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%h en=%b err=%b idx=%0d data=%h expected all 0",
                     busy, wr_en, err_waw, wr_index, wr_data);
        end
        vectors++;
        if (alu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_ready: got %b expected 0", alu_ready);
        end
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0]      m_busy;
        logic             m_err, m_wr_en;
        logic [IDX_W-1:0] m_wr_index, rd;
        logic [XLEN-1:0]  m_wr_data;
        int               m_starve;
        bit               alu_win, lsu_win, alu_hold, lsu_hold;

        @(negedge clk);
        reset_n = 1'b0;
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
        m_busy = '0; m_err = 1'b0; m_wr_en = 1'b0; m_wr_index = '0; m_wr_data = '0;
        m_starve = 0; alu_hold = 1'b0; lsu_hold = 1'b0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = 5'($urandom_range(0, 15));
                alu_data  = $urandom;
            end
            if (!lsu_hold) begin
                lsu_valid = ($urandom_range(0, 1) != 0);
                lsu_rd    = 5'($urandom_range(0, 15));
                lsu_data  = $urandom;
            end
            issue_rd = 5'($urandom_range(0, 15));
            issue_en = ($urandom_range(0, 3) == 0) && (!m_busy[issue_rd] || $urandom_range(0, 31) == 0);

            // LSU wins unless the ALU has already lost STARVE_MAX times in a row.
            lsu_win = lsu_valid && !(alu_valid && m_starve >= STARVE_MAX);
            alu_win = alu_valid && !lsu_win;
            #1;
            vectors++;
            if (alu_ready !== alu_win || lsu_ready !== lsu_win) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got alu=%b lsu=%b expected alu=%b lsu=%b",
                         cyc, alu_ready, lsu_ready, alu_win, lsu_win);
            end

            @(posedge clk); #1;
            if (issue_en && m_busy[issue_rd]) m_err = 1'b1;
            if (alu_win || lsu_win) begin
                rd         = alu_win ? alu_rd : lsu_rd;
                m_wr_en    = (rd != 0);
                m_wr_index = rd;
                m_wr_data  = alu_win ? alu_data : lsu_data;
                if (rd != 0) m_busy[rd] = 1'b0;
            end else begin
                m_wr_en = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (!alu_valid || alu_win) m_starve = 0;
            else if (lsu_win) m_starve++;
            alu_hold = alu_valid && !alu_win;
            lsu_hold = lsu_valid && !lsu_win;

            vectors++;
            if (wr_en !== m_wr_en || wr_index !== m_wr_index || wr_data !== m_wr_data) begin
                miscompares++;
                $display("FAIL rand_write[%0d]: got en=%b idx=%0d data=%h expected en=%b idx=%0d data=%h",
                         cyc, wr_en, wr_index, wr_data, m_wr_en, m_wr_index, m_wr_data);
            end
            vectors++;
            if (busy !== m_busy || err_waw !== m_err) begin
                miscompares++;
                $display("FAIL rand_scoreboard[%0d]: got busy=%h err=%b expected busy=%h err=%b",
                         cyc, busy, err_waw, m_busy, m_err);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_contention();
        test_x0_drop();
        test_scoreboard();
        test_set_clear_waw();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
